axi_read_arbiter: RTL
=====================

# axi_read_arbiter

Shares the single AXI read channel (AR/R) of the CPU between up to NUM_REQ read requesters: I-cache line refill, I-cache uncached fetch, D-cache line refill and D-cache uncached load. It sits between the cache AXI-side controllers and the CPU top-level AXI master port. It uses round-robin arbitration and keeps one transaction outstanding at a time. The R data of each burst is routed back to the requester that won.

## Interface
- NUM_REQ, 4, number of requesters; index 0 = I$ refill, 1 = I$ uncached, 2 = D$ refill, 3 = D$ uncached
- ID_WIDTH, 4, AXI ARID width; must satisfy 2^ID_WIDTH >= NUM_REQ
- DATA_WIDTH, 32, R data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*32  physical address; slice i = [32*i+31:32*i]
- req_len  in  NUM_REQ*8  AXI ARLEN, which is beats-1
- req_size  in  NUM_REQ*3  AXI ARSIZE
- req_ready  out  NUM_REQ  AR accepted for requester i (one-cycle pulse)
- rsp_valid  out  NUM_REQ  R beat valid for requester i
- rsp_ready  in  NUM_REQ  requester i accepts a beat
- rsp_data  out  DATA_WIDTH  R data, shared by all requesters
- rsp_last  out  1  last beat
- rsp_resp  out  2  RRESP
- m_arvalid/m_arready  out/in  1  AXI AR handshake
- m_araddr  out  32; m_arlen  out  8; m_arsize  out  3; m_arid  out  ID_WIDTH
- m_arburst  out  2  constant INCR (2'b01)
- m_arcache  out  4  constant 0
- m_arprot  out  3  constant 0
- m_rvalid/m_rready  in/out  1  AXI R handshake
- m_rdata  in  DATA_WIDTH; m_rresp  in  2; m_rlast  in  1; m_rid  in  ID_WIDTH
- busy  out  1  state is not IDLE

## Operation
- The block has three states: IDLE, ADDR and DATA. The state, the owner index and the round-robin pointer rr_ptr are registers.
- IDLE: when any req_valid bit is set, grant the first requester at or after rr_ptr, searching upward and wrapping from NUM_REQ-1 to 0.
  - Latch owner, addr, len and size into AR registers.
  - m_arid = owner.
  - Move to ADDR.
- ADDR: m_arvalid = 1, with the latched fields held stable.
  - On m_arready: req_ready[owner] = 1 combinationally in the same cycle, rr_ptr <= (owner+1) mod NUM_REQ, go to DATA.
- DATA:
  - rsp_valid[owner] = m_rvalid; all other rsp_valid bits = 0.
  - m_rready = rsp_ready[owner].
  - rsp_data, rsp_last and rsp_resp pass straight through from m_rdata, m_rlast and m_rresp.
  - On m_rvalid && m_rready && m_rlast, go to IDLE.
- m_rid is not checked, because only one transaction is outstanding.
- Requesters hold req_valid and their fields until req_ready. Deasserting req_valid after the grant does not cancel the transaction; it completes and its data is delivered.
- Beat counting is left to the requester. The arbiter ends the burst only on m_rlast.
- m_rready = 0 outside DATA; req_ready = 0 outside ADDR.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - m_arvalid = 0; m_araddr, m_arlen, m_arsize, m_arid = 0.
  - m_rready = 0, req_ready = 0, rsp_valid = 0, busy = 0.
- Grant latency: req_valid seen in IDLE at cycle t gives m_arvalid = 1 at t+1. If m_arready = 1 at t+1, req_ready pulses at t+1 and DATA starts at t+2.
- R path adds zero latency; rsp_valid and m_rready are combinational.
- Back-to-back: when the last beat is accepted at cycle t, the state is IDLE at t+1 and the next m_arvalid is at t+2. Minimum spacing is one bubble cycle.
- Simultaneous requests are resolved only by rr_ptr. With rr_ptr = 3 and requests {0,3}, requester 3 wins, then 0.
- Reset asserted mid-ADDR or mid-DATA: all outputs take their reset values immediately. The in-flight AXI transaction is abandoned; a whole-SoC reset is assumed around this block.
- A requester that receives rsp_valid with rsp_ready = 0 back-pressures AXI through m_rready = 0.

## Structure
- Shared package (CPU_Defines):
  - ArbState typedef enum {IDLE, ADDR, DATA}
  - AXI_BURST_INCR = 2'b01
  - requester index constants REQ_IREFILL = 0, REQ_IUNCACHE = 1, REQ_DREFILL = 2, REQ_DUNCACHE = 3
- Sub-module rr_pick: combinational, parameterised by NUM_REQ.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, grant index and any_req.

## Test plan
- Single I$ refill: req_valid = 0001, addr 0x1FC0_0000, len 7, arready high → m_arvalid at t+1, arid 0; 8 beats routed only to rsp_valid[0]; IDLE after rlast.
- All four requesters asserted with rr_ptr = 0 → grant order 0, 1, 2, 3 with one bubble between bursts; rr_ptr wraps to 0 afterwards.
- m_arready held low for 3 cycles → m_arvalid, m_araddr and m_arlen stay stable; req_ready pulses once, in the handshake cycle.
- rsp_ready[owner] low for 2 cycles during beat 3 of 8 → m_rready low for those 2 cycles; no beat lost or duplicated.
- D$ uncached request (len 0, size 2) → one beat with rlast; rsp_resp = 2'b10 (SLVERR) is passed through to requester 3.
- rst asserted during DATA beat 4 → state IDLE, m_rready = 0, busy = 0 immediately; a new request after reset is granted starting from rr_ptr = 0.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter_pkg
// Shared types and constants for the AXI read-channel arbiter:
//   - arb_state_e   : arbiter FSM states (IDLE / ADDR / DATA)
//   - ar_req_t      : latched AR payload (address, length, size)
//   - AXI constants : burst type, cache and protection attributes
//   - REQ_*         : requester index assignment
//   - idx_width()   : width of an index into N requesters (minimum 1)
// ---------------------------------------------------------------------------
package axi_read_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned LEN_WIDTH  = 8;
    localparam int unsigned SIZE_WIDTH = 3;
    localparam int unsigned RESP_WIDTH = 2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

    localparam int unsigned REQ_IREFILL  = 0;
    localparam int unsigned REQ_IUNCACHE = 1;
    localparam int unsigned REQ_DREFILL  = 2;
    localparam int unsigned REQ_DUNCACHE = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [SIZE_WIDTH-1:0] size;
    } ar_req_t;

    // Index width for n requesters; never zero so vectors stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter_rr_pick
// Combinational round-robin picker: selects the first asserted request at or
// above the pointer, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   i_req       in  NUM_REQ  request vector
//   i_rr_ptr    in  IDX_W    highest-priority index
//   o_grant     out NUM_REQ  one-hot grant (zero when no request)
//   o_grant_idx out IDX_W    index of the granted requester
//   o_any_req   out 1        at least one request asserted
// ---------------------------------------------------------------------------
module axi_read_arbiter_rr_pick
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_req
);

    logic w_found;

    // Two passes avoid modulo arithmetic: first the indices at or above the
    // pointer, then the wrapped range starting from 0.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (IDX_W'(i) >= i_rr_ptr)) begin
                w_found     = 1'b1;
                o_grant[i]  = 1'b1;
                o_grant_idx = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i]) begin
                w_found     = 1'b1;
                o_grant[i]  = 1'b1;
                o_grant_idx = IDX_W'(i);
            end
        end
        o_any_req = w_found;
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
// Shares one AXI read channel (AR/R) between NUM_REQ requesters using
// round-robin arbitration, one outstanding transaction at a time. R beats
// are steered back to the requester that won the AR grant.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/addr/len/size  per-requester AR request (slices of 1/32/8/3)
//   req_ready                AR accepted for requester i (one-cycle pulse)
//   rsp_valid/rsp_ready      per-requester R handshake
//   rsp_data/last/resp       shared R payload (pass-through)
//   m_ar*                    AXI AR master channel
//   m_r*                     AXI R master channel (m_rid ignored)
//   busy                     arbiter not idle
// ---------------------------------------------------------------------------
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
    input  logic [NUM_REQ*SIZE_WIDTH-1:0]    req_size,
    output logic [NUM_REQ-1:0]               req_ready,

    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             rsp_last,
    output logic [RESP_WIDTH-1:0]            rsp_resp,

    output logic                             m_arvalid,
    input  logic                             m_arready,
    output logic [ADDR_WIDTH-1:0]            m_araddr,
    output logic [LEN_WIDTH-1:0]             m_arlen,
    output logic [SIZE_WIDTH-1:0]            m_arsize,
    output logic [ID_WIDTH-1:0]              m_arid,
    output logic [1:0]                       m_arburst,
    output logic [3:0]                       m_arcache,
    output logic [2:0]                       m_arprot,

    input  logic                             m_rvalid,
    output logic                             m_rready,
    input  logic [DATA_WIDTH-1:0]            m_rdata,
    input  logic [RESP_WIDTH-1:0]            m_rresp,
    input  logic                             m_rlast,
    input  logic [ID_WIDTH-1:0]              m_rid,

    output logic                             busy
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [IDX_W-1:0]     r_owner;
    logic [NUM_REQ-1:0]   r_owner_oh;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     w_ptr_nxt;
    ar_req_t              r_ar;
    ar_req_t              w_ar_sel;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_any_req;
    logic                 w_take_grant;
    logic                 w_ar_hs;

    // Only one burst is ever in flight, so the returned ID carries no
    // information worth checking.
    logic                 w_unused_rid;
    assign w_unused_rid = ^m_rid;

    axi_read_arbiter_rr_pick #(
        .NUM_REQ     (NUM_REQ),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_req   (w_any_req)
    );

    // AR payload of the requester being granted this cycle.
    always_comb begin
        w_ar_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_ar_sel.addr = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                w_ar_sel.len  = req_len[LEN_WIDTH*i +: LEN_WIDTH];
                w_ar_sel.size = req_size[SIZE_WIDTH*i +: SIZE_WIDTH];
            end
        end
    end

    // Pointer moves just past the owner once its AR is accepted.
    assign w_ptr_nxt = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

    // State, owner, pointer and latched AR fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_owner_oh <= '0;
            r_rr_ptr   <= '0;
            r_ar       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_grant) begin
                r_owner    <= w_grant_idx;
                r_owner_oh <= w_grant;
                r_ar       <= w_ar_sel;
            end
            if (w_ar_hs) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    // Next state and per-requester handshake steering.
    always_comb begin
        w_state_nxt  = r_state;
        w_take_grant = 1'b0;
        w_ar_hs      = 1'b0;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        req_ready    = '0;
        rsp_valid    = '0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_take_grant = 1'b1;
                    w_state_nxt  = ADDR;
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    w_ar_hs     = 1'b1;
                    req_ready   = r_owner_oh;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                rsp_valid = r_owner_oh & {NUM_REQ{m_rvalid}};
                m_rready  = |(rsp_ready & r_owner_oh);
                if (m_rvalid && m_rready && m_rlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign m_araddr  = r_ar.addr;
    assign m_arlen   = r_ar.len;
    assign m_arsize  = r_ar.size;
    assign m_arid    = ID_WIDTH'(r_owner);
    assign m_arburst = AXI_BURST_INCR;
    assign m_arcache = AXI_CACHE_NONE;
    assign m_arprot  = AXI_PROT_NONE;

    assign rsp_data  = m_rdata;
    assign rsp_last  = m_rlast;
    assign rsp_resp  = m_rresp;

    assign busy      = (r_state != IDLE);

endmodule
